// File: rtl/lib_switchblock_pkg.sv
// Shared Q(I.F) format constants and types for the switch-block datapath.
package lib_switchblock_pkg;

    localparam int I = 4;
    localparam int F = 4;
    localparam int W = I + F;

    localparam logic [W-1:0] QMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] QMIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } rnd_mode_e;

    typedef struct packed {
        logic         sat;
        logic [W-1:0] val;
    } qres_t;

endpackage

// File: rtl/q_round_sat.sv
// Combinational round/shift/saturate of one full-width Q product back to W bits.
module q_round_sat
    import lib_switchblock_pkg::*;
(
    input  logic signed [2*W-1:0] prod,
    input  rnd_mode_e             rnd,
    output logic        [W-1:0]   res,
    output logic                  sat
);

    localparam logic signed [2*W:0] HALF = (2*W+1)'(1 << (F-1));
    localparam logic signed [2*W:0] ZERO = '0;

    // One guard bit above the product so the rounding add cannot wrap.
    function automatic logic signed [2*W:0] round_shift(input logic signed [2*W-1:0] p,
                                                         input rnd_mode_e m);
        logic signed [2*W:0] r;
        r = (2*W+1)'(p) + ((m == RND_HALF_UP) ? HALF : ZERO);
        return r >>> F;
    endfunction

    // In range only when every bit from the W-bit sign position upward agrees.
    function automatic qres_t saturate(input logic signed [2*W:0] s);
        qres_t q;
        if (s[2*W:W-1] == '0 || s[2*W:W-1] == '1) begin
            q.sat = 1'b0;
            q.val = s[W-1:0];
        end else if (s[2*W]) begin
            q.sat = 1'b1;
            q.val = QMIN;
        end else begin
            q.sat = 1'b1;
            q.val = QMAX;
        end
        return q;
    endfunction

    logic signed [2*W:0] shifted;
    qres_t               q;

    assign shifted = round_shift(prod, rnd);
    assign q       = saturate(shifted);
    assign res     = q.val;
    assign sat     = q.sat;

endmodule

// File: rtl/qmul_pipe_sat.sv
// Multi-lane 3-stage saturating Q(I.F) multiplier with valid/ready flow control
// and a sticky saturation event counter.
module qmul_pipe_sat
    import lib_switchblock_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [LANES*W-1:0]   a_i,
    input  logic [LANES*W-1:0]   b_i,
    input  logic                 round_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [LANES*W-1:0]   product_o,
    output logic [LANES-1:0]     sat_o,
    output logic [CNT_W-1:0]     sat_cnt_o,
    input  logic                 sat_clr_i
);

    logic                  en;
    logic                  vld_p0;
    logic                  vld_p1;
    rnd_mode_e             rnd_p0;
    rnd_mode_e             rnd_p1;
    logic signed [W-1:0]   a_p0    [LANES];
    logic signed [W-1:0]   b_p0    [LANES];
    logic signed [2*W-1:0] prod_p1 [LANES];
    logic        [W-1:0]   res_p1  [LANES];
    logic [LANES-1:0]      sat_p1;

    // The whole pipe moves in lockstep; it only freezes when the output is held.
    assign en         = !out_valid_o || out_ready_i;
    assign in_ready_o = en;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            out_valid_o <= 1'b0;
            product_o   <= '0;
            sat_o       <= '0;
        end else if (en) begin
            vld_p0      <= in_valid_i;
            vld_p1      <= vld_p0;
            out_valid_o <= vld_p1;
            for (int k = 0; k < LANES; k++) begin
                product_o[k*W +: W] <= res_p1[k];
            end
            sat_o       <= sat_p1 & {LANES{vld_p1}};
        end
    end

    // Stage 1: operand capture
    always_ff @(posedge clk_i) begin
        if (en) begin
            for (int k = 0; k < LANES; k++) begin
                a_p0[k] <= a_i[k*W +: W];
                b_p0[k] <= b_i[k*W +: W];
            end
            rnd_p0 <= rnd_mode_e'(round_i);
        end
    end

    // Stage 2: full-width signed products
    always_ff @(posedge clk_i) begin
        if (en) begin
            for (int k = 0; k < LANES; k++) begin
                prod_p1[k] <= (2*W)'(a_p0[k]) * (2*W)'(b_p0[k]);
            end
            rnd_p1 <= rnd_p0;
        end
    end

    // Stage 3: round/saturate feeding the output register
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        q_round_sat u_rs (
            .prod (prod_p1[k]),
            .rnd  (rnd_p1),
            .res  (res_p1[k]),
            .sat  (sat_p1[k])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sat_cnt_o <= '0;
        end else if (sat_clr_i) begin
            sat_cnt_o <= '0;
        end else if (out_valid_o && out_ready_i && (|sat_o) && (sat_cnt_o != '1)) begin
            sat_cnt_o <= sat_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_qmul_pipe_sat.sv
// Directed bench for qmul_pipe_sat with I=4, F=4, LANES=4 and hand-computed results.
module tb_qmul_pipe_sat;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        round_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] product_o;
    logic [3:0]  sat_o;
    logic [15:0] sat_cnt_o;
    logic        sat_clr_i;

    int vectors     = 0;
    int miscompares = 0;

    qmul_pipe_sat #(.LANES(4), .CNT_W(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .round_i     (round_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .product_o   (product_o),
        .sat_o       (sat_o),
        .sat_cnt_o   (sat_cnt_o),
        .sat_clr_i   (sat_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one beat with out_ready held high and collect its result.
    task automatic run_beat(input logic [31:0] a, input logic [31:0] b, input logic rnd,
                            output logic [31:0] p, output logic [3:0] s,
                            output logic [15:0] c, output int lat);
        a_i = a;
        b_i = b;
        round_i = rnd;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        p = product_o;
        s = sat_o;
        @(posedge clk_i); #1;
        c = sat_cnt_o;
    endtask

    logic [31:0] p;
    logic [3:0]  s;
    logic [15:0] c;
    int          lat;
    logic [31:0] exp_q [6];
    logic [31:0] held_p;
    logic        held_v;
    int          sent;
    int          got;
    int          stale;

    initial begin
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        a_i = '0;
        b_i = '0;
        round_i = 1'b0;
        out_ready_i = 1'b1;
        sat_clr_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_out_valid", 64'(out_valid_o), 64'h0);
        chk("rst_product", 64'(product_o), 64'h0);
        chk("rst_sat", 64'(sat_o), 64'h0);
        chk("rst_cnt", 64'(sat_cnt_o), 64'h0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("rst_in_ready", 64'(in_ready_o), 64'h1);

        // Nominal: 1.5 * 2.0 = 3.0 in lane 0
        run_beat(32'h0000_0018, 32'h0000_0020, 1'b0, p, s, c, lat);
        chk("nom_latency", 64'(lat), 64'd3);
        chk("nom_product", 64'(p), 64'h0000_0030);
        chk("nom_sat", 64'(s), 64'h0);
        chk("nom_cnt", 64'(c), 64'h0);

        // Overflow lanes 1..3, lane 0 = 0x10*0x10 = 1.0
        run_beat(32'h807F_8010, 32'h7F7F_8010, 1'b0, p, s, c, lat);
        chk("ovf_product", 64'(p), 64'h807F_7F10);
        chk("ovf_sat", 64'(s), 64'hE);
        chk("ovf_cnt", 64'(c), 64'h1);

        // Rounding, truncate: {-1*1, 1*1, -1/16*0.5, 1/16*0.5}
        run_beat(32'hF010_FF01, 32'h1010_0808, 1'b0, p, s, c, lat);
        chk("trunc_product", 64'(p), 64'hF010_FF00);
        chk("trunc_sat", 64'(s), 64'h0);

        // Same operands, round half up
        run_beat(32'hF010_FF01, 32'h1010_0808, 1'b1, p, s, c, lat);
        chk("rhu_product", 64'(p), 64'hF010_0001);
        chk("rhu_sat", 64'(s), 64'h0);
        chk("rhu_cnt", 64'(c), 64'h1);

        // Edge of range with rounding: 0x28*0x33 rounds up to 128 and clamps
        run_beat(32'h287F_807F, 32'h337F_1010, 1'b1, p, s, c, lat);
        chk("edge_product", 64'(p), 64'h7F7F_807F);
        chk("edge_sat", 64'(s), 64'hC);
        chk("edge_cnt", 64'(c), 64'h2);

        // Backpressure: out_ready low for cycles 4..7
        for (int k = 0; k < 6; k++) begin
            exp_q[k] = {8'(16*k+3), 8'(16*k+2), 8'(16*k+1), 8'(16*k)};
        end
        sent = 0;
        got = 0;
        held_v = 1'b0;
        held_p = '0;
        b_i = 32'h1010_1010;
        round_i = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready_i = !(cyc >= 4 && cyc <= 7);
            if (sent < 6) begin
                in_valid_i = 1'b1;
                a_i = exp_q[sent];
            end else begin
                in_valid_i = 1'b0;
            end
            @(negedge clk_i);
            if (cyc >= 4 && cyc <= 7) chk("bp_in_ready_stall", 64'(in_ready_o), 64'h0);
            if (held_v) begin
                chk("bp_hold_product", 64'(product_o), 64'(held_p));
                chk("bp_hold_valid", 64'(out_valid_o), 64'h1);
            end
            held_v = out_valid_o && !out_ready_i;
            held_p = product_o;
            if (out_valid_o && out_ready_i) begin
                if (got < 6) chk($sformatf("bp_order%0d", got), 64'(product_o), 64'(exp_q[got]));
                got++;
            end
            if (in_valid_i && in_ready_o) sent++;
            @(posedge clk_i); #1;
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        chk("bp_count", 64'(got), 64'd6);

        // Counter saturation
        sat_clr_i = 1'b1;
        @(posedge clk_i); #1;
        sat_clr_i = 1'b0;
        chk("cnt_clr_idle", 64'(sat_cnt_o), 64'h0);
        a_i = 32'h8080_8080;
        b_i = 32'h8080_8080;
        in_valid_i = 1'b1;
        repeat (70000) @(posedge clk_i);
        #1;
        chk("cnt_saturated", 64'(sat_cnt_o), 64'hFFFF);
        chk("cnt_stream_valid", 64'(out_valid_o), 64'h1);
        sat_clr_i = 1'b1;
        @(posedge clk_i); #1;
        sat_clr_i = 1'b0;
        chk("cnt_clr_priority", 64'(sat_cnt_o), 64'h0);
        @(posedge clk_i); #1;
        chk("cnt_resume", 64'(sat_cnt_o), 64'h1);
        in_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;

        // Asynchronous reset with two beats in flight
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid_o), 64'h0);
        chk("arst_cnt", 64'(sat_cnt_o), 64'h0);
        chk("arst_product", 64'(product_o), 64'h0);
        chk("arst_sat", 64'(sat_o), 64'h0);
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            if (out_valid_o) stale++;
        end
        chk("arst_no_stale", 64'(stale), 64'd0);
        chk("arst_in_ready", 64'(in_ready_o), 64'h1);

        run_beat(32'h0000_0018, 32'h0000_0020, 1'b0, p, s, c, lat);
        chk("post_rst_latency", 64'(lat), 64'd3);
        chk("post_rst_product", 64'(p), 64'h0000_0030);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qmul_pipe_sat.md
Name: qmul_pipe_sat

Overview:
Multi-lane, pipelined, signed fixed-point multiplier in Q(I.F) format with a selectable rounding mode and saturation.
- Each lane keeps I integer bits and F fractional bits (I and F come from lib_switchblock_pkg) and saturates to the W=I+F range.
- Saturation uses the full 2W-bit product, not only the retained slice.
- Valid/ready streaming, per-lane saturation flags and a sticky saturation event counter.
- Sits between the switch-block coefficient path and the DEM scrambler, replacing the single-cycle combinational multiplier wherever throughput or timing requires registering.

Parameters:
- LANES, 4, number of independent multiplier lanes sharing one handshake.
- CNT_W, 16, width of the saturation event counter.
- (I, F are package constants, not parameters. W = I+F.)

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  block can accept a beat this cycle.
- a_i  in  LANES*W  signed operand A, lane k at bits [k*W +: W].
- b_i  in  LANES*W  signed operand B, same packing.
- round_i  in  1  0 = truncate toward -inf, 1 = round half up; sampled with the beat.
- out_valid_o  out  1  result beat valid.
- out_ready_i  in  1  downstream accepts the result.
- product_o  out  LANES*W  signed saturated results, same packing.
- sat_o  out  LANES  per-lane flag; 1 = that lane was clamped.
- sat_cnt_o  out  CNT_W  count of output beats with any sat_o bit set.
- sat_clr_i  in  1  synchronous clear of sat_cnt_o.

Behaviour:
- Pipeline stages:
  - S1: register a, b, round, valid.
  - S2: register the full 2W-bit signed products per lane, plus round and valid.
  - S3: output register holding round/shift/saturate results.
- Stall and flow control:
  - en = !out_valid_o || out_ready_i. All three stages advance together when en=1 and hold when en=0.
  - in_ready_o = en (combinational). A beat is accepted when in_valid_i && in_ready_o.
  - Latency is 3 cycles from acceptance to out_valid_o with no backpressure. Throughput is 1 beat/cycle.
  - Bubbles are not collapsed.
  - product_o, sat_o and out_valid_o hold stable while out_valid_o && !out_ready_i.
- Arithmetic per lane (S2 to S3):
  - p = a*b, 2W-bit signed.
  - r = p + (round ? 2^(F-1) : 0), computed in 2W+1 bits.
  - s = r >>> F (arithmetic shift).
  - If s > 2^(W-1)-1: out = 0 followed by all ones, sat = 1.
  - If s < -2^(W-1): out = 1 followed by all zeros, sat = 1.
  - Otherwise out = s[W-1:0], sat = 0.
- Ties round toward +inf: -0.5 LSB gives 0, +0.5 LSB gives +1 LSB.
- sat_cnt_o:
  - Increments by 1 on each output handshake (out_valid_o && out_ready_i) where |sat_o = 1.
  - Saturates at all-ones and never wraps.
  - sat_clr_i has priority over an increment in the same cycle; the result is 0.
- Reset (rst_i=1, asynchronous, at any time including mid-stream):
  - All stage valid bits, out_valid_o, product_o, sat_o and sat_cnt_o go to 0.
  - In-flight beats are discarded.
  - in_ready_o = 1 after release.
- A round_i change mid-stream affects only beats accepted after the change.

Decomposition:
- lib_switchblock_pkg carries I and F, W = I+F, QMAX = {1'b0,{W-1{1'b1}}} and QMIN = {1'b1,{W-1{1'b0}}}, and a rnd_mode_e enum (RND_TRUNC=0, RND_HALF_UP=1).
- One sub-module, q_round_sat: combinational, takes a 2W-bit product and the round mode, returns a W-bit result and a sat flag. It is instantiated LANES times in S3.
- The top level holds the pipeline registers, the handshake and the counter.

Test Plan (package I=4, F=4, W=8; LANES=4):
- Nominal multiply: lane0 a=0x18 (1.5), b=0x20 (2.0), round=0. Expect 0x30 three cycles after acceptance, sat_o[0]=0.
- Overflow cases, all requiring sat_o=1 and sat_cnt_o=1 after the handshake:
  - a=0x80, b=0x80 (-8 * -8 = 64) gives 0x7F.
  - a=0x7F, b=0x7F gives 0x7F.
  - a=0x80, b=0x7F gives 0x80.
- Rounding: a=0x01 (0.0625), b=0x08 (0.5):
  - round=0 gives 0x00.
  - round=1 gives 0x01.
  - a=0xFF, b=0x08 with round=1 gives 0x00.
  - a=0xFF, b=0x08 with round=0 gives 0xFF.
- Backpressure: stream 6 incrementing beats while out_ready_i is held 0 for cycles 4-7. Expect:
  - in_ready_o=0 during the stall.
  - Outputs stable during the stall.
  - All 6 results delivered in order, none lost or duplicated.
- Counter: 70000 saturating beats with CNT_W=16 leave sat_cnt_o at 0xFFFF. sat_clr_i asserted together with a saturating handshake leaves 0.
- Reset mid-stream: assert rst_i asynchronously with 2 beats in flight. Expect out_valid_o=0 and sat_cnt_o=0 immediately, and no stale beat after release.
